// File: rtl/rv_pkg.sv
// Shared register-file constants and writeback source encoding for the
// writeback scheduler and its round-robin arbiter.
package rv_pkg;

    // Default datapath width of register write data.
    localparam int XLEN = 32;

    // Index width for a 32-entry architectural register file.
    localparam int REG_IDX_W = 5;

    // Writeback sources; the encoding doubles as the grant vector bit index.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    // x0 is hardwired to zero: writes to it are dropped, it is never busy.
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Bit 0 of the request/grant vectors is
// the ALU, bit 1 is the LSU. A registered favour bit picks the winner under
// contention and flips only when both requesters were present.
module rr_arbiter2 #(
    parameter bit ALU_FIRST = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);
    import rv_pkg::*;

    wb_src_e r_favour;
    logic    w_contend;

    assign w_contend = i_req[0] && i_req[1];

    // One-hot grant: a lone requester always wins, contention goes to the favoured side.
    always_comb begin
        o_grant = 2'b00;
        if (w_contend) begin
            if (r_favour == WB_ALU) begin
                o_grant = 2'b01;
            end else begin
                o_grant = 2'b10;
            end
        end else begin
            o_grant = i_req;
        end
    end

    // Favour bit: restored on reset, handed to the loser after every contended grant.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_favour <= ALU_FIRST ? WB_ALU : WB_LSU;
        end else if (w_contend) begin
            r_favour <= (r_favour == WB_ALU) ? WB_LSU : WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler. Arbitrates the single write port between
// the ALU and the LSU, registers the winning write for one cycle, and keeps a
// per-register pending-write scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int XLEN      = rv_pkg::XLEN,
    parameter int NREG      = 32,
    parameter bit ALU_FIRST = 1'b1,
    localparam int IDX_W    = $clog2(NREG)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    // ALU writeback request
    input  logic             i_alu_valid,
    input  logic [IDX_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]  i_alu_data,
    output logic             o_alu_ready,
    // LSU writeback request
    input  logic             i_lsu_valid,
    input  logic [IDX_W-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]  i_lsu_data,
    output logic             o_lsu_ready,
    // Issue-side hazard interface
    input  logic             i_issue_valid,
    input  logic             i_issue_has_rd,
    input  logic [IDX_W-1:0] i_issue_rd,
    input  logic [IDX_W-1:0] i_issue_rs1,
    input  logic [IDX_W-1:0] i_issue_rs2,
    output logic             o_stall,
    // Register file write port
    output logic             o_we,
    output logic [IDX_W-1:0] o_write_register,
    output logic [XLEN-1:0]  o_write_data
);
    import rv_pkg::*;

    localparam logic [IDX_W-1:0] W_ZERO_IDX = IDX_W'(REG_ZERO);

    logic [NREG-1:0]  r_busy;
    logic             r_we;
    logic [IDX_W-1:0] r_write_register;
    logic [XLEN-1:0]  r_write_data;

    logic [1:0]       w_grant;
    logic             w_alu_grant;
    logic             w_lsu_grant;
    logic             w_grant_any;
    logic [IDX_W-1:0] w_wb_rd;
    logic [XLEN-1:0]  w_wb_data;
    logic             w_wb_write;
    logic             w_issue_accept;
    logic             w_issue_sets;
    logic [NREG-1:0]  w_set_mask;
    logic [NREG-1:0]  w_clr_mask;

    rr_arbiter2 #(
        .ALU_FIRST (ALU_FIRST)
    ) u_arb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   ({i_lsu_valid, i_alu_valid}),
        .o_grant (w_grant)
    );

    assign w_alu_grant = w_grant[WB_ALU];
    assign w_lsu_grant = w_grant[WB_LSU];
    assign w_grant_any = w_alu_grant || w_lsu_grant;

    assign o_alu_ready = w_alu_grant;
    assign o_lsu_ready = w_lsu_grant;

    // Steer the granted source onto the writeback path.
    always_comb begin
        w_wb_rd   = i_alu_rd;
        w_wb_data = i_alu_data;
        if (w_lsu_grant) begin
            w_wb_rd   = i_lsu_rd;
            w_wb_data = i_lsu_data;
        end
    end

    // A grant to x0 is consumed but never reaches the register file.
    assign w_wb_write = w_grant_any && (w_wb_rd != W_ZERO_IDX);

    // Hazard stall: any operand or the destination still has a write pending.
    // A register whose writeback is granted this cycle is still busy here; its
    // value only reaches the register file on the next cycle.
    always_comb begin
        o_stall = i_issue_valid &&
                  (r_busy[i_issue_rs1] ||
                   r_busy[i_issue_rs2] ||
                   (i_issue_has_rd && r_busy[i_issue_rd]));
    end

    assign w_issue_accept = i_issue_valid && !o_stall;
    assign w_issue_sets   = w_issue_accept && i_issue_has_rd && (i_issue_rd != W_ZERO_IDX);

    // Per-cycle scoreboard updates from issue (set) and writeback (clear).
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_issue_sets) begin
            w_set_mask[i_issue_rd] = 1'b1;
        end
        if (w_wb_write) begin
            w_clr_mask[w_wb_rd] = 1'b1;
        end
    end

    // Scoreboard state: clear first, then set, so a newly issued writer wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    // Write port register: one cycle after the grant; index/data hold when idle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_we             <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
        end else begin
            r_we <= w_wb_write;
            if (w_wb_write) begin
                r_write_register <= w_wb_rd;
                r_write_data     <= w_wb_data;
            end
        end
    end

    assign o_we             = r_we;
    assign o_write_register = r_write_register;
    assign o_write_data     = r_write_data;

    // Every real writeback must retire a write that issue registered earlier.
    a_wb_to_busy : assert property (@(posedge i_clk) disable iff (i_reset)
        w_wb_write |-> r_busy[w_wb_rd]);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

    localparam int XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_alu_valid;
    logic [4:0]      i_alu_rd;
    logic [XLEN-1:0] i_alu_data;
    logic            o_alu_ready;
    logic            i_lsu_valid;
    logic [4:0]      i_lsu_rd;
    logic [XLEN-1:0] i_lsu_data;
    logic            o_lsu_ready;
    logic            i_issue_valid;
    logic            i_issue_has_rd;
    logic [4:0]      i_issue_rd;
    logic [4:0]      i_issue_rs1;
    logic [4:0]      i_issue_rs2;
    logic            o_stall;
    logic            o_we;
    logic [4:0]      o_write_register;
    logic [XLEN-1:0] o_write_data;

    regfile_wb_scheduler #(
        .XLEN      (XLEN),
        .NREG      (32),
        .ALU_FIRST (1'b1)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_alu_valid      (i_alu_valid),
        .i_alu_rd         (i_alu_rd),
        .i_alu_data       (i_alu_data),
        .o_alu_ready      (o_alu_ready),
        .i_lsu_valid      (i_lsu_valid),
        .i_lsu_rd         (i_lsu_rd),
        .i_lsu_data       (i_lsu_data),
        .o_lsu_ready      (o_lsu_ready),
        .i_issue_valid    (i_issue_valid),
        .i_issue_has_rd   (i_issue_has_rd),
        .i_issue_rd       (i_issue_rd),
        .i_issue_rs1      (i_issue_rs1),
        .i_issue_rs2      (i_issue_rs2),
        .o_stall          (o_stall),
        .o_we             (o_we),
        .o_write_register (o_write_register),
        .o_write_data     (o_write_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t q[$];
    int  checks = 0;
    int  errors = 0;
    bit  fav_lsu = 1'b0;   // model favour bit: 0 = ALU favoured
    bit  m_ga;             // model ALU grant for the cycle being driven
    bit  m_gl;             // model LSU grant for the cycle being driven

    // Scoreboard consumer: every register-file write must match the oldest expected one.
    always @(negedge i_clk) begin
        wr_t e;
        if (i_reset === 1'b0 && o_we === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got x%0d=%h, required no write", o_write_register, o_write_data);
            end else begin
                e = q.pop_front();
                if (o_write_register !== e.rd || o_write_data !== e.data) begin
                    errors++;
                    $display("FAIL wb_write got x%0d=%h, required x%0d=%h",
                             o_write_register, o_write_data, e.rd, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one cycle of inputs, predict the arbitration and queue expected writes.
    task automatic drive(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                         input logic iv, input logic ihas, input logic [4:0] ird,
                         input logic [4:0] irs1, input logic [4:0] irs2);
        i_alu_valid    = av;
        i_alu_rd       = ard;
        i_alu_data     = ad;
        i_lsu_valid    = lv;
        i_lsu_rd       = lrd;
        i_lsu_data     = ld;
        i_issue_valid  = iv;
        i_issue_has_rd = ihas;
        i_issue_rd     = ird;
        i_issue_rs1    = irs1;
        i_issue_rs2    = irs2;
        m_ga = av && (!lv || !fav_lsu);
        m_gl = lv && (!av || fav_lsu);
        if (av && lv) fav_lsu = !fav_lsu;
        if (m_ga && ard != 5'd0) q.push_back(wr_t'{rd: ard, data: ad});
        if (m_gl && lrd != 5'd0) q.push_back(wr_t'{rd: lrd, data: ld});
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        drive(0, 0, 0, 0, 0, 0, 1, 1, rd, 0, 0);
    endtask

    task automatic test_reset();
        checks++;
        if (o_we !== 1'b0 || o_write_register !== 5'd0 || o_write_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b reg=%0d data=%h, required 0/0/0", o_we, o_write_register, o_write_data);
        end
        i_reset = 1'b0;
        step();
        issue_rd(5);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_issue5 stall got %b, required 0", o_stall); end
        step();
        issue_rd(6);
        step();
        issue_rd(8);
        step();
        // contended grant moves the favour bit to the LSU before reset
        drive(1, 6, 32'h66, 1, 8, 32'h88, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_alu_ready !== 1'b1 || o_lsu_ready !== 1'b0) begin
            errors++; $display("FAIL reset_pre_arb got alu=%b lsu=%b, required 1/0", o_alu_ready, o_lsu_ready);
        end
        step();
        drive(0, 0, 0, 1, 8, 32'h88, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0);
        #1;
        checks++;
        if (o_we !== 1'b1 || o_write_register !== 5'd8 || o_stall !== 1'b1) begin
            errors++; $display("FAIL reset_pre_state got we=%b reg=%0d stall=%b, required 1/8/1", o_we, o_write_register, o_stall);
        end
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_we !== 1'b0 || o_write_register !== 5'd0 || o_write_data !== 32'd0 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got we=%b reg=%0d data=%h stall=%b, required 0/0/0/0",
                     o_we, o_write_register, o_write_data, o_stall);
        end
        q.delete();
        fav_lsu = 1'b0;
        step();
        idle();
        i_reset = 1'b0;
        step();
    endtask

    task automatic test_contention();
        issue_rd(3);
        step();
        issue_rd(4);
        step();
        drive(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_alu_ready !== 1'b1 || o_lsu_ready !== 1'b0) begin
            errors++; $display("FAIL contend_c1 got alu=%b lsu=%b, required 1/0", o_alu_ready, o_lsu_ready);
        end
        step();
        drive(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_alu_ready !== 1'b0 || o_lsu_ready !== 1'b1) begin
            errors++; $display("FAIL contend_c2 got alu=%b lsu=%b, required 0/1", o_alu_ready, o_lsu_ready);
        end
        checks++;
        if (o_we !== 1'b1 || o_write_register !== 5'd3 || o_write_data !== 32'h11) begin
            errors++; $display("FAIL contend_w3 got we=%b x%0d=%h, required 1 x3=11", o_we, o_write_register, o_write_data);
        end
        step();
        idle();
        @(negedge i_clk);
        checks++;
        if (o_we !== 1'b1 || o_write_register !== 5'd4 || o_write_data !== 32'h22) begin
            errors++; $display("FAIL contend_w4 got we=%b x%0d=%h, required 1 x4=22", o_we, o_write_register, o_write_data);
        end
        step();
    endtask

    task automatic test_raw();
        issue_rd(7);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 0);
            @(negedge i_clk);
            checks++;
            if (o_stall !== 1'b1) begin errors++; $display("FAIL raw_wait%0d stall got %b, required 1", i, o_stall); end
            step();
        end
        drive(0, 0, 0, 1, 7, 32'h77, 1, 0, 0, 7, 0);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b1 || o_lsu_ready !== 1'b1) begin
            errors++; $display("FAIL raw_grant got stall=%b lsu=%b, required 1/1", o_stall, o_lsu_ready);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 0);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0 || o_we !== 1'b1 || o_write_register !== 5'd7) begin
            errors++; $display("FAIL raw_release got stall=%b we=%b reg=%0d, required 0/1/7", o_stall, o_we, o_write_register);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_zero();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL zero_issue stall got %b, required 0", o_stall); end
        step();
        drive(1, 0, 32'hDEAD, 0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_alu_ready !== 1'b1 || o_stall !== 1'b0) begin
            errors++; $display("FAIL zero_grant got ready=%b stall=%b, required 1/0", o_alu_ready, o_stall);
        end
        step();
        idle();
        @(negedge i_clk);
        checks++;
        if (o_we !== 1'b0 || o_write_register !== 5'd7 || o_write_data !== 32'h77) begin
            errors++; $display("FAIL zero_nowrite got we=%b x%0d=%h, required 0 x7=77 held", o_we, o_write_register, o_write_data);
        end
        step();
    endtask

    task automatic test_collision();
        issue_rd(9);
        step();
        // writeback of x9 races a new writer of x9: the writer must wait a cycle
        drive(1, 9, 32'h91, 0, 0, 0, 1, 1, 9, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_alu_ready !== 1'b1 || o_stall !== 1'b1) begin
            errors++; $display("FAIL coll_same_cycle got ready=%b stall=%b, required 1/1", o_alu_ready, o_stall);
        end
        step();
        issue_rd(9);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL coll_reissue stall got %b, required 0", o_stall); end
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 9);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b1) begin errors++; $display("FAIL coll_rs2_busy stall got %b, required 1", o_stall); end
        step();
        drive(1, 9, 32'h92, 0, 0, 0, 1, 0, 0, 0, 9);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b1 || o_alu_ready !== 1'b1) begin
            errors++; $display("FAIL coll_second_wb got stall=%b ready=%b, required 1/1", o_stall, o_alu_ready);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 9);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL coll_release stall got %b, required 0", o_stall); end
        step();
        idle();
        step();
    endtask

    task automatic test_waw();
        issue_rd(12);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 12, 1, 2);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b1) begin errors++; $display("FAIL waw_stall stall got %b, required 1", o_stall); end
        step();
        drive(0, 0, 0, 1, 12, 32'hC0, 1, 1, 12, 1, 2);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b1 || o_lsu_ready !== 1'b1) begin
            errors++; $display("FAIL waw_grant got stall=%b lsu=%b, required 1/1", o_stall, o_lsu_ready);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 12, 1, 2);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin errors++; $display("FAIL waw_accept stall got %b, required 0", o_stall); end
        step();
        drive(0, 0, 0, 1, 12, 32'hC1, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_lsu_ready !== 1'b1) begin errors++; $display("FAIL waw_retire ready got %b, required 1", o_lsu_ready); end
        step();
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0]      alu_rd[4];
        logic [4:0]      lsu_rd[4];
        int              ai = 0;
        int              li = 0;
        int              guard = 0;
        logic [XLEN-1:0] ad;
        logic [XLEN-1:0] ld;
        alu_rd = '{5'd13, 5'd15, 5'd17, 5'd19};
        lsu_rd = '{5'd14, 5'd16, 5'd18, 5'd20};
        for (int r = 13; r <= 20; r++) begin
            issue_rd(5'(r));
            @(negedge i_clk);
            checks++;
            if (o_stall !== 1'b0) begin errors++; $display("FAIL b2b_issue x%0d stall got %b, required 0", r, o_stall); end
            step();
        end
        while ((ai < 4 || li < 4) && guard < 40) begin
            ad = $urandom;
            ld = $urandom;
            drive(ai < 4, (ai < 4) ? alu_rd[ai] : 5'd0, ad,
                  li < 4, (li < 4) ? lsu_rd[li] : 5'd0, ld, 0, 0, 0, 0, 0);
            @(negedge i_clk);
            checks++;
            if (o_alu_ready !== m_ga || o_lsu_ready !== m_gl) begin
                errors++;
                $display("FAIL b2b_arb got alu=%b lsu=%b, required %b/%b", o_alu_ready, o_lsu_ready, m_ga, m_gl);
            end
            step();
            if (m_ga) ai++;
            if (m_gl) li++;
            guard++;
        end
        checks++;
        if (guard >= 40) begin errors++; $display("FAIL b2b_timeout got %0d cycles, required < 40", guard); end
        idle();
        step();
        step();
    endtask

    initial begin
        i_reset = 1'b1;
        idle();
        repeat (2) @(posedge i_clk);
        #1;
        test_reset();
        test_contention();
        test_raw();
        test_zero();
        test_collision();
        test_waw();
        test_back_to_back();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL wb_missing got %0d writes outstanding, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
